// File: rtl/timer_pkg.sv
// Shared constants and channel state encoding for the multi-channel timer.
package timer_pkg;

    localparam int CHANNELS_DEF = 4;
    localparam int CNT_W_DEF    = 16;
    localparam int PRE_W_DEF    = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } ch_state_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: run FSM, counter, terminal-count pulse, sticky pending and PWM.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_tick,
    input  logic             i_enable,
    input  logic             i_oneshot,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_top,
    input  logic [CNT_W-1:0] i_compare,
    input  logic             i_irq_clr,
    output logic             o_interupt,
    output logic             o_pending,
    output logic             o_running,
    output logic             o_pwm,
    output logic [CNT_W-1:0] o_count
);

    ch_state_t        r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_irq;
    logic             r_pend;
    logic             r_pwm;

    ch_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_irq_nxt;
    logic             w_pwm_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_irq_nxt   = 1'b0;
        if (!i_enable) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_count_nxt = '0;
                    if (!i_oneshot || i_start)
                        w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    // >= so a top lowered below the live count still wraps
                    if (i_tick) begin
                        if (r_count >= i_top) begin
                            w_count_nxt = '0;
                            w_irq_nxt   = 1'b1;
                            if (i_oneshot)
                                w_state_nxt = S_DONE;
                        end else begin
                            w_count_nxt = r_count + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    w_count_nxt = '0;
                    if (i_start)
                        w_state_nxt = S_RUN;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    assign w_pwm_nxt = (w_state_nxt == S_RUN) && (w_count_nxt < i_compare);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_irq   <= 1'b0;
            r_pend  <= 1'b0;
            r_pwm   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_irq   <= w_irq_nxt;
            // a new interrupt beats a simultaneous clear
            r_pend  <= w_irq_nxt | (r_pend & ~i_irq_clr);
            r_pwm   <= w_pwm_nxt;
        end
    end

    assign o_interupt = r_irq;
    assign o_pending  = r_pend;
    assign o_running  = (r_state == S_RUN);
    assign o_pwm      = r_pwm;
    assign o_count    = r_count;

endmodule

// File: rtl/timer_multi.sv
// Multi-channel timer: one shared prescaler feeding CHANNELS independent counters.
module timer_multi
    import timer_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int PRE_W    = PRE_W_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [PRE_W-1:0]          prescaler,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       oneshot,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS*CNT_W-1:0] top,
    input  logic [CHANNELS*CNT_W-1:0] compare,
    input  logic [CHANNELS-1:0]       irq_clr,
    output logic                      tick,
    output logic [CHANNELS-1:0]       interupt,
    output logic [CHANNELS-1:0]       pending,
    output logic [CHANNELS-1:0]       running,
    output logic [CHANNELS-1:0]       pwm,
    output logic [CHANNELS*CNT_W-1:0] count
);

    logic [PRE_W-1:0] r_pre_cnt;
    logic [PRE_W-1:0] w_div_m1;
    logic             w_any_en;
    logic             w_tick;

    assign w_any_en = |enable;
    // divisor 0 behaves like 1
    assign w_div_m1 = (prescaler == '0) ? '0 : prescaler - PRE_W'(1);
    // >= lets a divisor lowered below the live count tick right away
    assign w_tick   = ~reset & w_any_en & (r_pre_cnt >= w_div_m1);
    assign tick     = w_tick;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_pre_cnt <= '0;
        else if (!w_any_en || w_tick)
            r_pre_cnt <= '0;
        else
            r_pre_cnt <= r_pre_cnt + PRE_W'(1);
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        timer_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .i_clock    (clock),
            .i_reset    (reset),
            .i_tick     (w_tick),
            .i_enable   (enable[g]),
            .i_oneshot  (oneshot[g]),
            .i_start    (start[g]),
            .i_top      (top[g*CNT_W +: CNT_W]),
            .i_compare  (compare[g*CNT_W +: CNT_W]),
            .i_irq_clr  (irq_clr[g]),
            .o_interupt (interupt[g]),
            .o_pending  (pending[g]),
            .o_running  (running[g]),
            .o_pwm      (pwm[g]),
            .o_count    (count[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_timer_multi.sv
// Bench for timer_multi: cycle reference model, period/PWM table, hand corner cases, random run.
module tb_timer_multi;

    localparam int CH = 4;
    localparam int CW = 16;
    localparam int PW = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic [PW-1:0]     prescaler;
    logic [CH-1:0]     enable, oneshot, start, irq_clr;
    logic [CH*CW-1:0]  top, compare;
    logic              tick;
    logic [CH-1:0]     interupt, pending, running, pwm;
    logic [CH*CW-1:0]  count;

    timer_multi #(.CHANNELS(CH), .CNT_W(CW), .PRE_W(PW)) dut (
        .clock(clock), .reset(reset), .prescaler(prescaler), .enable(enable),
        .oneshot(oneshot), .start(start), .top(top), .compare(compare),
        .irq_clr(irq_clr), .tick(tick), .interupt(interupt), .pending(pending),
        .running(running), .pwm(pwm), .count(count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // reference model: clocks since last tick, per-channel count and run/done flags
    int            m_pre;
    int            m_cnt [CH];
    bit            m_run [CH];
    bit            m_done[CH];
    logic [CH-1:0] m_irq, m_pend, m_pwm;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int top_of(int i);
        return int'(top[i*CW +: CW]);
    endfunction

    function automatic int cmp_of(int i);
        return int'(compare[i*CW +: CW]);
    endfunction

    function automatic bit mdl_tick();
        int div;
        div = (prescaler == 0) ? 1 : int'(prescaler);
        return !reset && (|enable) && (m_pre >= div - 1);
    endfunction

    task automatic model_reset();
        m_pre = 0;
        for (int i = 0; i < CH; i++) begin
            m_cnt[i] = 0; m_run[i] = 0; m_done[i] = 0;
        end
        m_irq = '0; m_pend = '0; m_pwm = '0;
    endtask

    task automatic model_edge();
        bit tk;
        tk = mdl_tick();
        for (int i = 0; i < CH; i++) begin
            m_irq[i] = 1'b0;
            if (!enable[i]) begin
                m_run[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
            end else if (m_run[i]) begin
                if (tk) begin
                    if (m_cnt[i] >= top_of(i)) begin
                        m_cnt[i] = 0;
                        m_irq[i] = 1'b1;
                        if (oneshot[i]) begin m_run[i] = 0; m_done[i] = 1; end
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end else if (m_done[i]) begin
                if (start[i]) begin m_run[i] = 1; m_done[i] = 0; end
            end else if (!oneshot[i] || start[i]) begin
                m_run[i] = 1;
            end
            m_pwm[i]  = m_run[i] && (m_cnt[i] < cmp_of(i));
            m_pend[i] = m_irq[i] | (m_pend[i] & ~irq_clr[i]);
        end
        m_pre = (!(|enable) || tk) ? 0 : m_pre + 1;
    endtask

    task automatic check_all();
        logic [CH*CW-1:0] ec;
        logic [CH-1:0]    er;
        for (int i = 0; i < CH; i++) begin
            ec[i*CW +: CW] = CW'(m_cnt[i]);
            er[i]          = m_run[i];
        end
        chk("tick", 64'(tick), 64'(mdl_tick()));
        chk("interupt", 64'(interupt), 64'(m_irq));
        chk("pending", 64'(pending), 64'(m_pend));
        chk("running", 64'(running), 64'(er));
        chk("pwm", 64'(pwm), 64'(m_pwm));
        chk("count", 64'(count), 64'(ec));
    endtask

    // compare at the falling edge, advance model, return just after the rising edge
    task automatic step();
        @(negedge clock);
        check_all();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_ch(int i, int t, int c);
        top[i*CW +: CW]     = CW'(t);
        compare[i*CW +: CW] = CW'(c);
    endtask

    typedef struct {
        int pre;
        int tp;
        int cmp;
        int exp_period;
        int exp_high;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n, c, h, pulses;

        vecs[0] = '{4, 2, 0, 12, 0};
        vecs[1] = '{1, 9, 3, 10, 3};
        vecs[2] = '{1, 9, 0, 10, 0};
        vecs[3] = '{1, 9, 20, 10, 10};
        vecs[4] = '{2, 3, 2, 8, 4};
        vecs[5] = '{0, 0, 1, 1, 1};
        vecs[6] = '{3, 1, 5, 6, 6};
        vecs[7] = '{0, 4, 2, 5, 2};

        reset = 1'b1; prescaler = '0; enable = '0; oneshot = '0; start = '0;
        irq_clr = '0; top = '0; compare = '0;
        model_reset();
        @(negedge clock);
        check_all();
        @(posedge clock); #1;
        reset = 1'b0;

        // period and PWM duty table on channel 0
        foreach (vecs[k]) begin
            do_reset();
            prescaler = PW'(vecs[k].pre);
            set_ch(0, vecs[k].tp, vecs[k].cmp);
            oneshot = '0;
            enable  = 4'b0001;
            n = 0;
            while (!interupt[0] && n < 200) begin step(); n++; end
            chk("first_irq_timeout", 64'(n < 200), 64'(1));
            c = 0; h = 0;
            do begin
                step(); c++;
                if (pwm[0]) h++;
            end while (!interupt[0] && c < 200);
            chk("irq_period", 64'(c), 64'(vecs[k].exp_period));
            chk("pwm_high", 64'(h), 64'(vecs[k].exp_high));
        end

        // prescaler 0, top 0: tick and interupt stay high
        do_reset();
        prescaler = '0; set_ch(0, 0, 0); enable = 4'b0001;
        step(); step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("cont_tick", 64'(tick), 64'(1));
            chk("cont_irq", 64'(interupt[0]), 64'(1));
        end

        // one-shot on channel 1
        do_reset();
        prescaler = PW'(2); set_ch(1, 3, 0);
        oneshot = 4'b0010; enable = 4'b0010; start = 4'b0010;
        step(); start = '0; n = 1;
        while (!interupt[1] && n < 40) begin step(); n++; end
        chk("oneshot_latency", 64'(n), 64'(8));
        pulses = 0;
        for (int i = 0; i < 12; i++) begin step(); if (interupt[1]) pulses++; end
        chk("oneshot_extra", 64'(pulses), 64'(0));
        chk("oneshot_done", 64'(running[1]), 64'(0));
        start = 4'b0010; step(); start = '0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin step(); if (interupt[1]) pulses++; end
        chk("oneshot_rearm", 64'(pulses), 64'(1));
        chk("oneshot_done2", 64'(running[1]), 64'(0));

        // pending set/clear collision on channel 2
        do_reset();
        prescaler = PW'(1); set_ch(2, 3, 0); enable = 4'b0100;
        n = 0;
        while (count[2*CW +: CW] != CW'(3) && n < 40) begin step(); n++; end
        chk("pend_wait", 64'(n < 40), 64'(1));
        irq_clr = 4'b0100;
        step();
        chk("pend_collide_irq", 64'(interupt[2]), 64'(1));
        chk("pend_collide", 64'(pending[2]), 64'(1));
        step();
        chk("pend_clear", 64'(pending[2]), 64'(0));
        irq_clr = '0;

        // async reset mid-count with all channels running
        do_reset();
        prescaler = PW'(4);
        for (int i = 0; i < CH; i++) set_ch(i, 2, 1);
        oneshot = '0; enable = 4'b1111;
        for (int i = 0; i < 19; i++) step();
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("rst_tick", 64'(tick), 64'(0));
        chk("rst_irq", 64'(interupt), 64'(0));
        chk("rst_pend", 64'(pending), 64'(0));
        chk("rst_run", 64'(running), 64'(0));
        chk("rst_pwm", 64'(pwm), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        n = 0;
        while (!interupt[0] && n < 50) begin step(); n++; end
        chk("rst_first_irq", 64'(n), 64'(12));

        // randomized run against the model
        do_reset();
        prescaler = PW'(1);
        for (int i = 0; i < CH; i++) set_ch(i, $urandom_range(0, 6), $urandom_range(0, 8));
        enable = 4'b1111; oneshot = 4'(($urandom));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 39) == 0) enable[i] = ~enable[i];
                if ($urandom_range(0, 59) == 0) oneshot[i] = ~oneshot[i];
                if ($urandom_range(0, 79) == 0) set_ch(i, $urandom_range(0, 6), $urandom_range(0, 8));
                start[i]   = ($urandom_range(0, 9) == 0);
                irq_clr[i] = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 99) == 0) prescaler = PW'($urandom_range(0, 4));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
- Parametrised successor to the single-channel timer: one shared prescaler drives CHANNELS independent counters.
- Each channel has its own top, periodic or one-shot mode, a sticky pending flag and a PWM compare output.
- Sits between the board clock and LED/peripheral logic; replaces per-use timer instances that each carried their own prescaler.

Parameters:
CHANNELS, 4, number of independent counter channels
CNT_W, 16, width of each channel counter, top and compare
PRE_W, 16, width of shared prescaler divisor

Ports:
clock  input  1  single system clock
reset  input  1  asynchronous, active-high reset
prescaler  input  PRE_W  divisor; tick every max(prescaler,1) clocks
enable  input  CHANNELS  per-channel run enable
oneshot  input  CHANNELS  1 = one-shot mode, 0 = periodic
start  input  CHANNELS  one-cycle pulse; arms/re-arms a one-shot channel
top  input  CHANNELS*CNT_W  per-channel terminal count, channel i at [i*CNT_W +: CNT_W]
compare  input  CHANNELS*CNT_W  per-channel PWM threshold, same packing
irq_clr  input  CHANNELS  clears pending
tick  output  1  prescaler tick, one-cycle pulse
interupt  output  CHANNELS  one-cycle terminal-count pulse
pending  output  CHANNELS  sticky interrupt flag
running  output  CHANNELS  channel in RUN state
pwm  output  CHANNELS  registered PWM output
count  output  CHANNELS*CNT_W  current channel counts

Behaviour:
- Reset values: all outputs 0, prescaler counter 0, all channels in IDLE. Reset mid-operation aborts immediately, with no trailing interupt.
- Prescaler:
  - pre_cnt advances only while any enable bit is high. Otherwise it is held at 0 and tick is 0.
  - Tick asserts for the cycle in which pre_cnt >= max(prescaler,1)-1; pre_cnt then returns to 0.
  - Using >= makes a divisor lowered below the current pre_cnt produce a tick on the next cycle.
  - prescaler = 0 or 1 gives a tick every cycle.
- Channel FSM, states IDLE / RUN / DONE:
  - IDLE: count = 0. Transitions:
    - enable & ~oneshot -> RUN.
    - enable & oneshot & start -> RUN.
  - RUN, on tick:
    - If count >= top (the >= covers top lowered mid-run): count <= 0 and interupt pulses.
    - Then periodic stays in RUN; one-shot goes to DONE with count <= 0.
    - Else count <= count+1.
  - Without a tick, count holds.
  - DONE: count holds 0; start -> RUN.
  - Any state: enable low -> IDLE next cycle, count cleared, no interupt. pending is untouched.
- Timing:
  - Periodic period = (top+1) * max(prescaler,1) clocks.
  - interupt is registered: high for exactly one clock, on the same edge that count returns to 0.
  - top = 0 with prescaler <= 1 means interupt is continuously high.
- Pending: set on interupt, cleared by irq_clr. If set and clear occur in the same cycle, set wins.
- PWM: registered; pwm <= (next state is RUN) & (next count < compare).
  - compare = 0 gives constant low.
  - compare > top gives constant high while in RUN.
  - Low in IDLE and DONE.
- Mode change while running: oneshot is sampled only on the terminal tick; a change takes effect at the next wrap.
- Width rules: count, top and compare are unsigned CNT_W; no carry beyond CNT_W. Comparisons are unsigned.

Decomposition:
- Shared header/package timer_pkg:
  - state localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default width constants.
- Sub-module timer_channel (one per channel, generate loop) holds the FSM, count, interupt, pending and pwm.
- The prescaler stays in timer_multi.

Test Plan:
- prescaler=4, top=2, ch0 periodic enabled -> tick every 4 clocks; interupt[0] every 12 clocks; count sequence 0,1,2,0.
- prescaler=0, top=0 -> tick constantly high; interupt[0] constantly high after the first cycle.
- ch1 oneshot, prescaler=2, top=3, start pulse -> single interupt 8 clocks later, then DONE with running=0; second start -> another single pulse.
- Pending collision: interupt and irq_clr in the same cycle -> pending stays 1; irq_clr alone next cycle -> 0.
- PWM: prescaler=1, top=9, compare=3 -> pwm high 3 of every 10 clocks; compare=0 -> always low; compare=20 -> always high.
- Async reset asserted mid-count with ch0..ch3 running -> all outputs 0 immediately; after release, the first interupt arrives a full period later.
